cam_pixel_capture: RTL and testbench
====================================

# cam_pixel_capture

Downstream camera capture stage. Consumes the IO-registered 8-bit camera bus (`cam_dat`, `cam_href`, `cam_vsync`) from the top-level pin wrapper. Captures one frame per `start` request, assembles byte pairs into RGB565 pixels with optional power-of-two decimation, and presents them on a valid/ready stream through a small FIFO. It also drives `cam_dat_en`, the clock enable of the data IO registers.

## Interface
- `IMG_WIDTH`, 640: sensor pixels per line (2 bytes each).
- `IMG_HEIGHT`, 480: sensor lines per frame.
- `DEC_LOG2`, 0: decimation exponent 0..3; one pixel kept per 2^D × 2^D block.
- `FIFO_DEPTH`, 4: output FIFO entries, power of two.
- `clk` in 1: camera pixel clock, same net as the IO register clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to capture the next full frame.
- `cam_dat` in 8: registered camera data.
- `cam_href` in 1: registered line-valid.
- `cam_vsync` in 1: registered frame sync (high during vertical blanking).
- `cam_dat_en` out 1: clock enable for the data IO registers.
- `busy` out 1: capture in progress.
- `done` out 1: one-cycle pulse at frame end.
- `overflow` out 1: sticky; a pixel was dropped because the FIFO was full.
- `pix_data` out 16: RGB565; first byte → [15:8], second byte → [7:0].
- `pix_eol` out 1: last kept pixel of a line.
- `pix_eof` out 1: last kept pixel of the frame.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: stream ready.

## Operation
- States: IDLE → ARM → FRAME → CAPTURE → IDLE.
- IDLE: on `start`, clear `overflow` and go to ARM.
- ARM: wait for `cam_vsync`=1 (blanking). This guarantees a capture starts on a frame boundary, never mid-frame.
- FRAME: on `cam_vsync`=0, clear the row, column and byte-phase counters and go to CAPTURE.
- CAPTURE, byte handling: while `cam_href`=1, bytes alternate hi/lo. On a lo byte, form a pixel at (col,row) and increment col.
- CAPTURE, pixel keep rule: the pixel is kept iff col[D-1:0]=0, row[D-1:0]=0, col<IMG_WIDTH and row<IMG_HEIGHT.
- CAPTURE, line end: on the `cam_href` falling edge, row increments, col clears and byte phase clears. An odd trailing byte is discarded silently.
- CAPTURE, frame end: on the `cam_vsync` rising edge, go to IDLE and pulse `done`. Short frames end the same way; `pix_eof` is then simply never produced.
- Line/frame flags: `pix_eol` is set when col = IMG_WIDTH − 2^D. `pix_eof` is set when `pix_eol` holds and row = IMG_HEIGHT − 2^D.
- Counter saturation: col and row stop at IMG_WIDTH and IMG_HEIGHT. Out-of-range bytes are ignored.
- `cam_dat_en` = 1 in FRAME and CAPTURE, 0 otherwise. This freezes the pads while idle.
- `busy` = 1 in ARM, FRAME and CAPTURE.
- `start` while busy is ignored.
- Kept pixel with FIFO full: the pixel is dropped and `overflow` is set. Later pixels are still accepted once space frees.
- FIFO contents survive IDLE and a new `start`. Only `reset` flushes the FIFO.

## Timing
- Reset values: `cam_dat_en`=0, `busy`=0, `done`=0, `overflow`=0, `pix_valid`=0; `pix_data`, `pix_eol`, `pix_eof` = 0. State is IDLE, FIFO empty.
- Reset mid-capture: IDLE on the next edge. No `done` pulse; all output flags as above.
- `start` at cycle N → `busy`=1 at N+1.
- Lo byte sampled at cycle N into an empty FIFO → `pix_valid`=1 at N+1.
- Stream handshake: transfer when `pix_valid` and `pix_ready` are both 1. Data is stable while valid and not ready.
- FIFO full with a pop in the same cycle as a push: not full, push accepted.
- `done` is asserted the cycle after the vsync rising edge is seen. It is independent of FIFO drain.

## Structure
- Shared `cam_pkg` holds:
  - the RGB565 pixel width constant;
  - the state encoding;
  - a `byte_phase` type;
  - the maximum-resolution constants used to size the counters (clog2 of IMG_WIDTH+1 and IMG_HEIGHT+1).
- One sub-module: `cam_pixel_fifo`. It is a synchronous show-ahead FIFO, 18 bits wide (data, eol, eof), with full/empty flags and no almost-flags.

## Test plan
- Capture start alignment, D=0, 4×2 frame:
  - Stimulus: assert `start` mid-frame.
  - Response: no pixels until the next vsync fall.
  - Bytes 0x12,0x34 → `pix_data`=0x1234. 8 pixels total; `pix_eol` on pixels 4 and 8; `pix_eof` on pixel 8; one `done`.
- Decimation, D=1, 8×4 frame:
  - Response: exactly 8 pixels (cols 0,2,4,6 of rows 0 and 2).
  - `pix_eol` at col 6; `pix_eof` at row 2, col 6.
- Back-pressure and overflow:
  - Stimulus: `pix_ready`=0 for a 6-pixel line, FIFO_DEPTH=4.
  - Response: first 4 pixels retained in order; `overflow`=1.
  - A later `start` clears `overflow`; the retained 4 pixels drain unchanged.
- Odd byte and short frame:
  - Stimulus: 7-byte href pulse, then vsync rise.
  - Response: 3 pixels; trailing byte dropped; `done` pulses; no `pix_eof`.
- Reset during CAPTURE with 2 pixels queued:
  - Response: next cycle `pix_valid`=0, `busy`=0, `cam_dat_en`=0, no `done`.
  - A new `start` then captures a clean frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture stage: pixel width,
// FSM encoding, byte phase and counter sizing for the largest supported frame.
package cam_pkg;
  localparam int PIX_W          = 16;
  localparam int FIFO_W         = PIX_W + 2;
  localparam int MAX_IMG_WIDTH  = 640;
  localparam int MAX_IMG_HEIGHT = 480;
  localparam int COL_W          = $clog2(MAX_IMG_WIDTH + 1);
  localparam int ROW_W          = $clog2(MAX_IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_FRAME   = 2'd2,
    ST_CAPTURE = 2'd3
  } cam_state_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } byte_phase_t;

  // FIFO entry layout: {hi byte, lo byte, eol, eof}
  function automatic logic [FIFO_W-1:0] pack_entry(input logic [7:0] hi, input logic [7:0] lo,
                                                   input logic eol, input logic eof);
    return {hi, lo, eol, eof};
  endfunction
endpackage

// File: rtl/cam_pixel_fifo.sv
// Synchronous show-ahead FIFO for captured pixels; head entry is visible
// whenever the FIFO is not empty. A pop in the same cycle frees room for a push.
module cam_pixel_fifo
  import cam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [FIFO_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [FIFO_W-1:0] o_rdata,
  output logic              o_empty,
  output logic              o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [FIFO_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Pointer and storage update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + LP_PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + LP_PTR_ONE;
      end
    end
  end
endmodule

// File: rtl/cam_pixel_capture.sv
// Frame-aligned camera capture: pairs bytes into RGB565 pixels, decimates by
// 2^DEC_LOG2 in both axes and queues kept pixels on a valid/ready stream.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DEC_LOG2   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [7:0]       i_cam_dat,
  input  logic             i_cam_href,
  input  logic             i_cam_vsync,
  output logic             o_cam_dat_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_pix_eol,
  output logic             o_pix_eof,
  output logic             o_pix_valid,
  input  logic             i_pix_ready
);
  localparam logic [COL_W-1:0] LP_COL_LIM  = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] LP_ROW_LIM  = ROW_W'(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LP_COL_STEP = COL_W'(1 << DEC_LOG2);
  localparam logic [ROW_W-1:0] LP_ROW_STEP = ROW_W'(1 << DEC_LOG2);
  localparam logic [COL_W-1:0] LP_COL_MASK = LP_COL_STEP - COL_W'(1);
  localparam logic [ROW_W-1:0] LP_ROW_MASK = LP_ROW_STEP - ROW_W'(1);
  localparam logic [COL_W-1:0] LP_COL_EOL  = LP_COL_LIM - LP_COL_STEP;
  localparam logic [ROW_W-1:0] LP_ROW_EOF  = LP_ROW_LIM - LP_ROW_STEP;

  cam_state_t        r_state;
  cam_state_t        w_next_state;
  byte_phase_t       r_phase;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [7:0]        r_hi;
  logic              r_href_d;
  logic              r_done;
  logic              r_overflow;
  logic              r_busy;
  logic              r_dat_en;
  logic              w_clr_ovf;
  logic              w_frame_start;
  logic              w_frame_end;
  logic              w_cap;
  logic              w_lo_byte;
  logic              w_line_end;
  logic              w_keep;
  logic              w_eol;
  logic              w_eof;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic [FIFO_W-1:0] w_rdata;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and frame-level strobes
  always_comb begin
    w_next_state  = r_state;
    w_clr_ovf     = 1'b0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_ARM;
          w_clr_ovf    = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (i_cam_vsync) begin
          w_next_state = ST_FRAME;
        end else begin
          w_next_state = ST_ARM;
        end
      end
      ST_FRAME: begin
        if (!i_cam_vsync) begin
          w_next_state  = ST_CAPTURE;
          w_frame_start = 1'b1;
        end else begin
          w_next_state = ST_FRAME;
        end
      end
      ST_CAPTURE: begin
        if (i_cam_vsync) begin
          w_next_state = ST_IDLE;
          w_frame_end  = 1'b1;
        end else begin
          w_next_state = ST_CAPTURE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // CAPTURE is entered with vsync low, so vsync high there is always the rising edge
  assign w_cap      = (r_state == ST_CAPTURE) && !i_cam_vsync;
  assign w_lo_byte  = w_cap && i_cam_href && (r_phase == PH_LO);
  assign w_line_end = w_cap && r_href_d && !i_cam_href;
  assign w_keep     = w_lo_byte && (r_col < LP_COL_LIM) && (r_row < LP_ROW_LIM) &&
                      ((r_col & LP_COL_MASK) == '0) && ((r_row & LP_ROW_MASK) == '0);
  assign w_eol      = (r_col == LP_COL_EOL);
  assign w_eof      = w_eol && (r_row == LP_ROW_EOF);
  assign w_pop      = o_pix_valid && i_pix_ready;
  assign w_drop     = w_keep && w_full && !w_pop;

  // Byte pairing, counters and status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase    <= PH_HI;
      r_col      <= '0;
      r_row      <= '0;
      r_hi       <= 8'h00;
      r_href_d   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_dat_en   <= 1'b0;
    end else begin
      r_done   <= w_frame_end;
      r_busy   <= (w_next_state != ST_IDLE);
      r_dat_en <= (w_next_state == ST_FRAME) || (w_next_state == ST_CAPTURE);
      r_href_d <= w_cap ? i_cam_href : 1'b0;
      if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_frame_start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_phase <= PH_HI;
      end else if (w_line_end) begin
        r_col   <= '0;
        r_phase <= PH_HI;
        if (r_row < LP_ROW_LIM) begin
          r_row <= r_row + ROW_W'(1);
        end
      end else if (w_cap && i_cam_href) begin
        if (r_phase == PH_HI) begin
          r_hi    <= i_cam_dat;
          r_phase <= PH_LO;
        end else begin
          r_phase <= PH_HI;
          if (r_col < LP_COL_LIM) begin
            r_col <= r_col + COL_W'(1);
          end
        end
      end
    end
  end

  cam_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_keep),
    .i_wdata (pack_entry(r_hi, i_cam_dat, w_eol, w_eof)),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_cam_dat_en = r_dat_en;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_pix_valid  = !w_empty;
  assign {o_pix_data, o_pix_eol, o_pix_eof} = w_rdata;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed + randomized bench for cam_pixel_capture; expected pixel streams are
// derived from the frame's recorded bytes using the keep/eol/eof rules.
module tb_cam_pixel_capture;
  logic clk, reset;
  logic [7:0] cam_dat;
  logic cam_href, cam_vsync;
  logic start_a, ready_a, dat_en_a, busy_a, done_a, ovf_a, eol_a, eof_a, valid_a;
  logic start_b, ready_b, dat_en_b, busy_b, done_b, ovf_b, eol_b, eof_b, valid_b;
  logic start_c, ready_c, dat_en_c, busy_c, done_c, ovf_c, eol_c, eof_c, valid_c;
  logic [15:0] data_a, data_b, data_c;

  int checks = 0;
  int failures = 0;
  bit rnd_ready = 1'b0;
  bit hold_a = 1'b0;
  bit hold_c = 1'b0;
  bit last_r = 1'b1;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic [17:0] got_a[$];
  logic [17:0] got_b[$];
  logic [17:0] got_c[$];
  logic [17:0] act_q[$];
  logic [17:0] exp_q[$];
  logic [7:0] byte_q[$];
  int len_q[$];

  cam_pixel_capture #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .DEC_LOG2(0), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_cam_dat(cam_dat), .i_cam_href(cam_href),
    .i_cam_vsync(cam_vsync), .o_cam_dat_en(dat_en_a), .o_busy(busy_a), .o_done(done_a),
    .o_overflow(ovf_a), .o_pix_data(data_a), .o_pix_eol(eol_a), .o_pix_eof(eof_a),
    .o_pix_valid(valid_a), .i_pix_ready(ready_a));

  cam_pixel_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .DEC_LOG2(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_cam_dat(cam_dat), .i_cam_href(cam_href),
    .i_cam_vsync(cam_vsync), .o_cam_dat_en(dat_en_b), .o_busy(busy_b), .o_done(done_b),
    .o_overflow(ovf_b), .o_pix_data(data_b), .o_pix_eol(eol_b), .o_pix_eof(eof_b),
    .o_pix_valid(valid_b), .i_pix_ready(ready_b));

  cam_pixel_capture #(.IMG_WIDTH(6), .IMG_HEIGHT(2), .DEC_LOG2(0), .FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_reset(reset), .i_start(start_c), .i_cam_dat(cam_dat), .i_cam_href(cam_href),
    .i_cam_vsync(cam_vsync), .o_cam_dat_en(dat_en_c), .o_busy(busy_c), .o_done(done_c),
    .o_overflow(ovf_c), .o_pix_data(data_c), .o_pix_eol(eol_c), .o_pix_eof(eof_c),
    .o_pix_valid(valid_c), .i_pix_ready(ready_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Transfers happen at the next rising edge when valid and ready are both high here
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_a && ready_a) got_a.push_back({data_a, eol_a, eof_a});
      if (valid_b && ready_b) got_b.push_back({data_b, eol_b, eof_b});
      if (valid_c && ready_c) got_c.push_back({data_c, eol_c, eof_c});
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ready never stays low two cycles in a row, so the FIFO cannot overflow in random mode
  task automatic cyc();
    bit r;
    @(posedge clk);
    #1;
    if (rnd_ready) r = (last_r == 1'b0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    else r = 1'b1;
    last_r = r;
    ready_a = hold_a ? 1'b0 : r;
    ready_b = r;
    ready_c = hold_c ? 1'b0 : r;
  endtask

  task automatic put_byte(input logic [7:0] b);
    cam_href = 1'b1;
    cam_dat = b;
    byte_q.push_back(b);
    len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
    cyc();
  endtask

  task automatic line_begin();
    len_q.push_back(0);
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic send_line(input int n);
    line_begin();
    repeat (n) put_byte(8'($urandom_range(0, 255)));
    line_end();
  endtask

  task automatic frame_open();
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) cyc();
    cam_vsync = 1'b0;
    byte_q.delete();
    len_q.delete();
    repeat (2) cyc();
  endtask

  task automatic frame_close();
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (2) cyc();
  endtask

  // Expected stream: pixel c of line r kept when inside the image and on the decimation grid
  task automatic build_model(input int w, input int h, input int d);
    int idx, s;
    logic eol, eof;
    exp_q.delete();
    idx = 0;
    s = 1 << d;
    for (int r = 0; r < len_q.size(); r++) begin
      for (int c = 0; c < len_q[r] / 2; c++) begin
        eol = (c == w - s);
        eof = eol && (r == h - s);
        if (c < w && r < h && (c % s) == 0 && (r % s) == 0)
          exp_q.push_back({byte_q[idx + 2*c], byte_q[idx + 2*c + 1], eol, eof});
      end
      idx += len_q[r];
    end
  endtask

  task automatic cmp_stream(input string tag, input int limit);
    int n;
    n = (exp_q.size() < limit) ? exp_q.size() : limit;
    chk({tag, " count"}, 32'(act_q.size()), 32'(n));
    for (int i = 0; i < n && i < act_q.size(); i++)
      chk({tag, " pixel"}, 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
  endtask

  initial begin
    int d0, nl, eofs;
    reset = 1'b1; cam_dat = 8'h00; cam_href = 1'b0; cam_vsync = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) cyc();
    chk("reset valid", 32'(valid_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset dat_en", 32'(dat_en_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset overflow", 32'(ovf_a), 32'd0);
    chk("reset pix", 32'({data_a, eol_a, eof_a}), 32'd0);
    reset = 1'b0;
    cyc();

    // Start requested mid-frame: nothing captured until the next frame
    got_a.delete(); done_cnt_a = 0;
    cam_href = 1'b1;
    repeat (3) begin cam_dat = 8'($urandom_range(0, 255)); cyc(); end
    pulse_start_a();
    chk("t1 busy after start", 32'(busy_a), 32'd1);
    chk("t1 dat_en in arm", 32'(dat_en_a), 32'd0);
    repeat (4) begin cam_dat = 8'($urandom_range(0, 255)); cyc(); end
    cam_href = 1'b0;
    repeat (3) cyc();
    chk("t1 no midframe pixels", 32'(valid_a), 32'd0);
    frame_open();
    chk("t1 dat_en in capture", 32'(dat_en_a), 32'd1);
    line_begin();
    put_byte(8'h12);
    put_byte(8'h34);
    chk("t1 first valid", 32'(valid_a), 32'd1);
    chk("t1 first data", 32'(data_a), 32'h1234);
    repeat (6) put_byte(8'($urandom_range(0, 255)));
    line_end();
    send_line(8);
    cam_vsync = 1'b1;
    cyc();
    chk("t1 done pulse", 32'(done_a), 32'd1);
    cyc();
    chk("t1 done cleared", 32'(done_a), 32'd0);
    chk("t1 idle busy", 32'(busy_a), 32'd0);
    repeat (6) cyc();
    build_model(4, 2, 0);
    act_q = got_a;
    cmp_stream("t1 stream", 1000);
    chk("t1 pixel total", 32'(got_a.size()), 32'd8);
    chk("t1 done count", 32'(done_cnt_a), 32'd1);

    // Randomized frames with random back-pressure, including row/column saturation
    rnd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got_a.delete(); d0 = done_cnt_a;
      pulse_start_a();
      frame_open();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 11));
      frame_close();
      repeat (8) cyc();
      build_model(4, 2, 0);
      act_q = got_a;
      cmp_stream("t2 random stream", 1000);
      chk("t2 done count", 32'(done_cnt_a), 32'(d0 + 1));
      chk("t2 no overflow", 32'(ovf_a), 32'd0);
    end

    // Decimation by 2: first frame is the full 8x4 image, later ones random
    for (int k = 0; k < 3; k++) begin
      got_b.delete(); d0 = done_cnt_b;
      start_b = 1'b1; cyc(); start_b = 1'b0;
      frame_open();
      if (k == 0) begin
        repeat (4) send_line(16);
      end else begin
        nl = $urandom_range(1, 5);
        for (int l = 0; l < nl; l++) send_line($urandom_range(1, 20));
      end
      frame_close();
      repeat (8) cyc();
      build_model(8, 4, 1);
      act_q = got_b;
      cmp_stream("t3 decim stream", 1000);
      if (k == 0) chk("t3 full frame count", 32'(got_b.size()), 32'd8);
      chk("t3 done count", 32'(done_cnt_b), 32'(d0 + 1));
    end
    rnd_ready = 1'b0;

    // Back-pressure: 6-pixel line into a 4-entry FIFO
    got_c.delete(); hold_c = 1'b1;
    start_c = 1'b1; cyc(); start_c = 1'b0;
    frame_open();
    send_line(12);
    frame_close();
    chk("t4 overflow set", 32'(ovf_c), 32'd1);
    chk("t4 valid held", 32'(valid_c), 32'd1);
    chk("t4 nothing drained", 32'(got_c.size()), 32'd0);
    build_model(6, 2, 0);
    start_c = 1'b1; cyc(); start_c = 1'b0;
    chk("t4 overflow cleared", 32'(ovf_c), 32'd0);
    hold_c = 1'b0;
    repeat (8) cyc();
    act_q = got_c;
    cmp_stream("t4 retained", 4);

    // Odd trailing byte in a short frame
    got_a.delete(); d0 = done_cnt_a;
    pulse_start_a();
    frame_open();
    send_line(7);
    frame_close();
    repeat (6) cyc();
    build_model(4, 2, 0);
    act_q = got_a;
    cmp_stream("t5 short stream", 1000);
    chk("t5 pixel total", 32'(got_a.size()), 32'd3);
    eofs = 0;
    foreach (got_a[i]) if (got_a[i][0]) eofs++;
    chk("t5 no eof", 32'(eofs), 32'd0);
    chk("t5 done count", 32'(done_cnt_a), 32'(d0 + 1));

    // Reset during capture with two pixels queued, then a clean frame
    got_a.delete(); d0 = done_cnt_a; hold_a = 1'b1;
    pulse_start_a();
    frame_open();
    line_begin();
    repeat (4) put_byte(8'($urandom_range(0, 255)));
    chk("t6 queued valid", 32'(valid_a), 32'd1);
    reset = 1'b1;
    cyc();
    chk("t6 reset valid", 32'(valid_a), 32'd0);
    chk("t6 reset busy", 32'(busy_a), 32'd0);
    chk("t6 reset dat_en", 32'(dat_en_a), 32'd0);
    chk("t6 reset done", 32'(done_a), 32'd0);
    reset = 1'b0; cam_href = 1'b0; hold_a = 1'b0;
    repeat (3) cyc();
    chk("t6 no done", 32'(done_cnt_a), 32'(d0));
    chk("t6 nothing drained", 32'(got_a.size()), 32'd0);
    pulse_start_a();
    frame_open();
    send_line(8);
    send_line(8);
    frame_close();
    repeat (6) cyc();
    build_model(4, 2, 0);
    act_q = got_a;
    cmp_stream("t6 clean stream", 1000);
    chk("t6 done count", 32'(done_cnt_a), 32'(d0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
